gpio_responder: RTL and testbench
=================================

GPIO_RESPONDER -- requirements
Module: gpio_responder

Interface
REQ-001 SHALL have parameter READ_PORT_WIDTH, default 4, width of the driven read_port.
REQ-002 SHALL have parameter WRITE_PORT_WIDTH, default 4, width of the sampled write_port.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, number of entries in the change FIFO (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port write_port  input  WRITE_PORT_WIDTH  asynchronous GPIO bus from the initiator.
REQ-007 SHALL have port read_port  output  READ_PORT_WIDTH  registered GPIO bus driven toward the initiator.
REQ-008 SHALL have port drv_valid  input  1  request to update read_port.
REQ-009 SHALL have port drv_ready  output  1  block can accept a drive request.
REQ-010 SHALL have port drv_data  input  READ_PORT_WIDTH  value for read_port.
REQ-011 SHALL have port drv_hold  input  8  minimum cycles read_port holds the value before the next request is accepted.
REQ-012 SHALL have port chg_valid  output  1  change FIFO not empty.
REQ-013 SHALL have port chg_ready  input  1  consumer pops the FIFO head.
REQ-014 SHALL have port chg_data  output  WRITE_PORT_WIDTH  FIFO head, i.e. the synchronized write_port value after a change.
REQ-015 SHALL have port overflow  output  1  sticky flag for a change dropped because the FIFO was full.
REQ-016 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-017 SHALL pass write_port through a two-flop synchronizer (sync1, sync2) before any comparison.
REQ-018 SHALL track synchronizer fill with a 2-bit valid shift register and ignore sync2 until both stages hold post-reset samples.
REQ-019 SHALL push sync2 into the FIFO on the first valid cycle after reset, regardless of value, and load it into the last-value register.
REQ-020 SHALL thereafter push sync2 and update last-value on any cycle where sync2 differs from last-value in any bit.
REQ-021 SHALL give this latency: a write_port change set up before edge E0 is written at edge E2, and chg_valid is high after E2.
REQ-022 SHALL provide a show-ahead FIFO: chg_data equals the head whenever chg_valid=1, and a pop occurs on an edge with chg_valid&chg_ready.
REQ-023 SHALL write into the slot freed by a pop when a push and a pop happen in the same cycle with the FIFO full; overflow is not set.
REQ-024 SHALL drop a push when the FIFO is full and not popping, set overflow, and still update last-value.
REQ-025 SHALL give overflow set priority over ovf_clr in the same cycle.
REQ-026 SHALL implement the drive FSM with states IDLE and HOLD; drv_ready=1 only in IDLE.
REQ-027 SHALL, in IDLE, on drv_valid, register drv_data to read_port at that edge; if drv_hold=0 it stays in IDLE, else it loads a counter with drv_hold and goes to HOLD.
REQ-028 SHALL, in HOLD, decrement the counter each cycle and return to IDLE on the edge where the counter reaches 1, with drv_ready=1 the following cycle.
REQ-029 SHALL ignore drv_valid in HOLD with no effect on read_port (no queuing).
REQ-030 SHALL keep read_port capture and change detection independent; driving read_port never generates FIFO entries.

Reset
REQ-031 SHALL, on rst low, asynchronously clear: read_port=0, sync1/sync2=0, valid shift=0, last-value=0, FIFO empty (chg_valid=0, chg_data=0), overflow=0, FSM=IDLE, counter=0.
REQ-032 SHALL hold drv_ready=0 while rst is low and drive it to 1 from the first edge after release.
REQ-033 SHALL, on reset mid-HOLD or with a non-empty FIFO, discard all state, and the first post-reset valid sample is re-pushed per REQ-019.

Configuration
REQ-034 SHALL support macro GPIO_RESPONDER_GLITCH_FILTER_EN; when defined, a change is pushed only after sync2 holds the new value for 2 consecutive cycles, adding one cycle to the REQ-021 latency (write at E3); single-cycle pulses are never pushed.
REQ-035 SHALL, without GPIO_RESPONDER_GLITCH_FILTER_EN, behave exactly per REQ-020/REQ-021 with no filter logic present.

Verification
REQ-036 SHALL cover: release reset with write_port=4'hA -> exactly one entry 4'hA, chg_valid high 2 edges after valid fill.
REQ-037 SHALL cover: write_port 4'h0->4'h5->4'h5->4'hF with chg_ready=1 -> entries 0,5,F in order, no duplicate 5.
REQ-038 SHALL cover: chg_ready=0 and 5 distinct changes with FIFO_DEPTH=4 -> 4 entries kept, 5th dropped, overflow=1; ovf_clr with a simultaneous drop -> overflow stays 1.
REQ-039 SHALL cover: drv_valid with drv_data=4'h3, drv_hold=3 -> read_port=3 next cycle, drv_ready low 3 cycles; drv_valid=4'h9 during HOLD -> ignored.
REQ-040 SHALL cover: drv_hold=0 back-to-back requests 4'h1,4'h2 -> read_port updates on consecutive edges.
REQ-041 SHALL cover: with GPIO_RESPONDER_GLITCH_FILTER_EN, a 1-cycle write_port pulse 4'h0->4'h8->4'h0 -> no entry; without the macro -> entries 8 then 0.

Source files
------------

// File: rtl/gpio_responder.sv
// -----------------------------------------------------------------------------
// gpio_responder
//
// Purpose:
//   Responder side of a simple GPIO link. It drives a registered read_port
//   toward the initiator under a valid/ready request with a programmable
//   minimum hold time, and watches the asynchronous write_port bus, queueing
//   every observed change in a small show-ahead FIFO for a local consumer.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous reset, active low
//   write_port  in   [WRITE_PORT_WIDTH] asynchronous GPIO bus from initiator
//   read_port   out  [READ_PORT_WIDTH]  registered GPIO bus toward initiator
//   drv_valid   in   request to update read_port
//   drv_ready   out  block can accept a drive request
//   drv_data    in   [READ_PORT_WIDTH]  value for read_port
//   drv_hold    in   [8] cycles read_port holds before the next request
//   chg_valid   out  change FIFO not empty
//   chg_ready   in   consumer pops the FIFO head
//   chg_data    out  [WRITE_PORT_WIDTH] FIFO head
//   overflow    out  sticky: a change was dropped because the FIFO was full
//   ovf_clr     in   clears overflow (a simultaneous drop wins)
//
// Configuration:
//   GPIO_RESPONDER_GLITCH_FILTER_EN - when defined, a synchronized value must
//   be stable for two consecutive cycles before it counts as a change; this
//   adds one cycle of latency and suppresses single-cycle pulses.
// -----------------------------------------------------------------------------
module gpio_responder #(
  parameter int READ_PORT_WIDTH  = 4,
  parameter int WRITE_PORT_WIDTH = 4,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WRITE_PORT_WIDTH-1:0] write_port,
  output logic [READ_PORT_WIDTH-1:0]  read_port,
  input  logic                        drv_valid,
  output logic                        drv_ready,
  input  logic [READ_PORT_WIDTH-1:0]  drv_data,
  input  logic [7:0]                  drv_hold,
  output logic                        chg_valid,
  input  logic                        chg_ready,
  output logic [WRITE_PORT_WIDTH-1:0] chg_data,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } drv_state_t;

  logic [WRITE_PORT_WIDTH-1:0] sync1;
  logic [WRITE_PORT_WIDTH-1:0] sync2;
  logic [1:0]                  sync_vld;
  logic [WRITE_PORT_WIDTH-1:0] last_val;
  logic                        primed;
  logic                        sample_ok;
  logic                        push_req;

  logic [WRITE_PORT_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            fifo_cnt;
  logic                        fifo_empty;
  logic                        fifo_full;
  logic                        pop;
  logic                        push_ok;
  logic                        drop;

  drv_state_t                  state;
  drv_state_t                  state_next;
  logic [7:0]                  hold_cnt;
  logic                        rdy_en;
  logic                        drv_accept;

  // Two-flop synchronizer plus a fill tracker; sync2 is only trusted once
  // both stages have captured post-reset samples (sync_vld[1]).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= 2'b00;
    end else begin
      sync1    <= write_port;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

`ifdef GPIO_RESPONDER_GLITCH_FILTER_EN
  logic [WRITE_PORT_WIDTH-1:0] sync3;
  logic                        sync3_vld;

  // One more stage of history so a value is accepted only after sync2 has
  // shown it on two consecutive cycles; single-cycle pulses never match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync3     <= '0;
      sync3_vld <= 1'b0;
    end else begin
      sync3     <= sync2;
      sync3_vld <= sync_vld[1];
    end
  end

  assign sample_ok = sync_vld[1] && sync3_vld && (sync2 == sync3);
`else
  assign sample_ok = sync_vld[1];
`endif

  // The very first trusted sample after reset is always reported, even if it
  // matches the reset value of last_val; afterwards only real changes count.
  assign push_req = sample_ok && (!primed || (sync2 != last_val));

  // last_val tracks what was observed, not what was stored, so a dropped
  // change does not keep re-triggering every cycle while the FIFO is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_val <= '0;
      primed   <= 1'b0;
    end else if (push_req) begin
      last_val <= sync2;
      primed   <= 1'b1;
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign pop        = !fifo_empty && chg_ready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign chg_valid  = !fifo_empty;
  assign chg_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // Circular show-ahead FIFO. A push while full is still accepted when the
  // head is popped on the same edge, reusing the slot just freed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= sync2;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky overflow; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Drive FSM state register, hold counter and the read_port register.
  // rdy_en keeps drv_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      read_port <= '0;
      rdy_en    <= 1'b0;
    end else begin
      state  <= state_next;
      rdy_en <= 1'b1;
      if (drv_accept) begin
        read_port <= drv_data;
      end
      if (drv_accept && (drv_hold != 8'd0)) begin
        hold_cnt <= drv_hold;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

  // Next-state logic: a zero hold keeps the FSM in IDLE so requests can be
  // taken on consecutive edges; HOLD exits on the edge the counter hits 1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (drv_accept && (drv_hold != 8'd0)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt <= 8'd1) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs of the drive FSM; requests arriving in HOLD are simply ignored.
  always_comb begin
    drv_ready  = rdy_en && (state == IDLE);
    drv_accept = drv_ready && drv_valid;
  end

endmodule

// File: tb/tb_gpio_responder.sv
// -----------------------------------------------------------------------------
// tb_gpio_responder
//
// Purpose:
//   Directed self-checking bench for gpio_responder with default parameters.
//   Inputs change 1 time unit after a rising edge and outputs are sampled at
//   the same point, well away from the active edge.
//   Honours GPIO_RESPONDER_GLITCH_FILTER_EN for the expected change latency
//   and the expected result of the single-cycle pulse test.
// -----------------------------------------------------------------------------
module tb_gpio_responder;

  localparam int RW    = 4;
  localparam int WW    = 4;
  localparam int DEPTH = 4;
`ifdef GPIO_RESPONDER_GLITCH_FILTER_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] write_port;
  logic [RW-1:0] read_port;
  logic          drv_valid;
  logic          drv_ready;
  logic [RW-1:0] drv_data;
  logic [7:0]    drv_hold;
  logic          chg_valid;
  logic          chg_ready;
  logic [WW-1:0] chg_data;
  logic          overflow;
  logic          ovf_clr;

  int            num_checks = 0;
  int            num_errors = 0;
  logic [WW-1:0] got_q[$];
  logic [WW-1:0] exp_q[$];

  gpio_responder #(
    .READ_PORT_WIDTH (RW),
    .WRITE_PORT_WIDTH(WW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write_port(write_port),
    .read_port (read_port),
    .drv_valid (drv_valid),
    .drv_ready (drv_ready),
    .drv_data  (drv_data),
    .drv_hold  (drv_hold),
    .chg_valid (chg_valid),
    .chg_ready (chg_ready),
    .chg_data  (chg_data),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold write_port at a value for some cycles; optionally record each FIFO
  // head that is popped (sampled before the edge that pops it).
  task automatic applyStimulus(input logic [WW-1:0] value, input int cycles,
                               input bit collect);
    write_port = value;
    for (int i = 0; i < cycles; i++) begin
      if (collect && chg_valid && chg_ready) begin
        got_q.push_back(chg_data);
      end
      tick();
    end
  endtask

  // Compare the recorded entries with the expected list, then clear both.
  task automatic checkQueue(input string tag);
    checkOutput({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checkOutput($sformatf("%s entry%0d", tag, i), got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Overall time bound so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    write_port = 4'hA;
    drv_valid  = 1'b0;
    drv_data   = '0;
    drv_hold   = '0;
    chg_ready  = 1'b0;
    ovf_clr    = 1'b0;

    // Reset values and first-sample push of 4'hA.
    $display("[TB] reset and first sample");
    tick();
    tick();
    checkOutput("rst read_port", read_port, 4'h0);
    checkOutput("rst chg_valid", chg_valid, 1'b0);
    checkOutput("rst chg_data", chg_data, 4'h0);
    checkOutput("rst overflow", overflow, 1'b0);
    checkOutput("rst drv_ready", drv_ready, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("post-rst drv_ready", drv_ready, 1'b1);
    checkOutput("fill chg_valid e1", chg_valid, 1'b0);
    for (int i = 0; i < 1 + EXTRA; i++) begin
      tick();
      checkOutput("fill chg_valid early", chg_valid, 1'b0);
    end
    tick();
    checkOutput("first push chg_valid", chg_valid, 1'b1);
    checkOutput("first push chg_data", chg_data, 4'hA);
    tick();
    tick();
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    checkOutput("single entry popped", chg_valid, 1'b0);
    tick();
    tick();
    checkOutput("no duplicate of A", chg_valid, 1'b0);

    // Change sequence 0 -> 5 -> 5 -> F with the consumer always ready.
    $display("[TB] change sequence");
    chg_ready = 1'b1;
    applyStimulus(4'h0, 5, 1'b1);
    applyStimulus(4'h5, 5, 1'b1);
    applyStimulus(4'h5, 5, 1'b1);
    applyStimulus(4'hF, 5, 1'b1);
    exp_q = '{4'h0, 4'h5, 4'hF};
    checkQueue("seq");
    chg_ready = 1'b0;

    // Fill, overflow, clear priority and push-into-freed-slot.
    $display("[TB] overflow");
    applyStimulus(4'h1, 4, 1'b0);
    applyStimulus(4'h2, 4, 1'b0);
    applyStimulus(4'h3, 4, 1'b0);
    applyStimulus(4'h4, 4, 1'b0);
    checkOutput("full no overflow", overflow, 1'b0);
    checkOutput("full head", chg_data, 4'h1);
    applyStimulus(4'h6, 4, 1'b0);
    checkOutput("drop sets overflow", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_clr clears", overflow, 1'b0);
    write_port = 4'h7;
    for (int i = 0; i < 2 + EXTRA; i++) begin
      tick();
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("drop beats ovf_clr", overflow, 1'b1);
    tick();
    checkOutput("overflow sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checkOutput("ovf_clr clears again", overflow, 1'b0);
    write_port = 4'h8;
    for (int i = 0; i < 2 + EXTRA; i++) begin
      tick();
    end
    chg_ready = 1'b1;
    tick();
    chg_ready = 1'b0;
    checkOutput("push+pop when full no ovf", overflow, 1'b0);
    checkOutput("head after push+pop", chg_data, 4'h2);
    chg_ready = 1'b1;
    applyStimulus(4'h8, 8, 1'b1);
    exp_q = '{4'h2, 4'h3, 4'h4, 4'h8};
    checkQueue("drain");
    checkOutput("drained empty", chg_valid, 1'b0);

    // Drive with hold of 3; a request during HOLD is ignored.
    $display("[TB] drive with hold");
    drv_hold  = 8'd3;
    drv_data  = 4'h3;
    drv_valid = 1'b1;
    checkOutput("idle drv_ready", drv_ready, 1'b1);
    tick();
    checkOutput("drive read_port", read_port, 4'h3);
    checkOutput("hold ready c1", drv_ready, 1'b0);
    drv_data = 4'h9;
    tick();
    checkOutput("hold ready c2", drv_ready, 1'b0);
    checkOutput("hold ignores 9 c2", read_port, 4'h3);
    tick();
    checkOutput("hold ready c3", drv_ready, 1'b0);
    checkOutput("hold ignores 9 c3", read_port, 4'h3);
    tick();
    checkOutput("ready after hold", drv_ready, 1'b1);
    checkOutput("read_port after hold", read_port, 4'h3);
    drv_valid = 1'b0;
    checkOutput("drive makes no entry", chg_valid, 1'b0);
    tick();
    checkOutput("read_port stays 3", read_port, 4'h3);

    // Zero hold: back-to-back requests on consecutive edges.
    $display("[TB] zero hold back-to-back");
    drv_hold  = 8'd0;
    drv_data  = 4'h1;
    drv_valid = 1'b1;
    tick();
    checkOutput("b2b first", read_port, 4'h1);
    checkOutput("b2b ready", drv_ready, 1'b1);
    drv_data = 4'h2;
    tick();
    checkOutput("b2b second", read_port, 4'h2);
    drv_valid = 1'b0;
    drv_data  = 4'h4;
    tick();
    checkOutput("no request keeps value", read_port, 4'h2);

    // Single-cycle pulse 0 -> 8 -> 0.
    $display("[TB] single-cycle pulse");
    chg_ready = 1'b1;
    applyStimulus(4'h0, 6, 1'b1);
    applyStimulus(4'h8, 1, 1'b1);
    applyStimulus(4'h0, 8, 1'b1);
`ifdef GPIO_RESPONDER_GLITCH_FILTER_EN
    exp_q = '{4'h0};
`else
    exp_q = '{4'h0, 4'h8, 4'h0};
`endif
    checkQueue("pulse");
    chg_ready = 1'b0;

    // Reset in the middle of HOLD with a non-empty FIFO.
    $display("[TB] reset mid-hold");
    applyStimulus(4'hC, 5, 1'b0);
    checkOutput("pre-rst entry", chg_data, 4'hC);
    drv_hold  = 8'd5;
    drv_data  = 4'h6;
    drv_valid = 1'b1;
    tick();
    drv_valid = 1'b0;
    checkOutput("pre-rst in hold", drv_ready, 1'b0);
    checkOutput("pre-rst read_port", read_port, 4'h6);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async rst chg_valid", chg_valid, 1'b0);
    checkOutput("async rst read_port", read_port, 4'h0);
    checkOutput("async rst drv_ready", drv_ready, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("re-rst drv_ready", drv_ready, 1'b1);
    checkOutput("re-rst chg_valid e1", chg_valid, 1'b0);
    for (int i = 0; i < 1 + EXTRA; i++) begin
      tick();
      checkOutput("re-rst chg_valid early", chg_valid, 1'b0);
    end
    tick();
    checkOutput("re-push chg_valid", chg_valid, 1'b1);
    checkOutput("re-push chg_data", chg_data, 4'hC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_checks, num_errors);
    $finish;
  end

endmodule
